// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, one-cycle synchronous imem, 2-entry {pc, inst} buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect halts fetch and raises sticky fetch_error.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_error
`endif
);

  logic [31:0] fetch_pc_reg;
  logic        pending_reg;
  logic [31:0] pending_pc_reg;
  logic [1:0]  count_reg;
  logic [31:0] pc_q   [2];
  logic [31:0] inst_q [2];

  logic        run;
  logic        aligned;
  logic [31:0] redirect_target;
  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;
  logic        wr_idx;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} mode_t;
  mode_t mode_reg, mode_next;
  logic  error_next;

  assign aligned = (redirect_pc[1:0] == 2'b00);
  assign run     = (mode_reg == RUN);

  always_comb begin
    mode_next  = mode_reg;
    error_next = fetch_error;
    if (redirect_valid) begin
      mode_next  = aligned ? RUN : HALT;
      error_next = !aligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg    <= RUN;
      fetch_error <= 1'b0;
    end else begin
      mode_reg    <= mode_next;
      fetch_error <= error_next;
    end
  end
`else
  assign aligned = 1'b1;
  assign run     = 1'b1;
`endif

  // Low bits are dropped; in trap builds they only matter through 'aligned'.
  assign redirect_target = redirect_pc & ~32'h3;

  assign out_valid = (count_reg != 2'd0) && !redirect_valid && run;
  assign out_pc    = pc_q[0];
  assign out_inst  = inst_q[0];
  assign pop       = out_valid && out_ready;
  assign push      = pending_reg && !redirect_valid;

  // Words held after this edge if nothing new is issued; issue only while room remains.
  assign occupancy = {1'b0, count_reg} + {2'b00, pending_reg} - {2'b00, pop};
  assign issue     = run && !redirect_valid && (occupancy < 3'd2);
  assign imem_addr = redirect_valid ? redirect_target : fetch_pc_reg;

  // Slot the incoming word lands in after any same-cycle pop has shifted the buffer.
  assign wr_idx = (count_reg == 2'd2) || ((count_reg == 2'd1) && !pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg   <= RESET_PC;
      pending_reg    <= 1'b0;
      pending_pc_reg <= 32'h0;
      count_reg      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= 32'h0;
        inst_q[i] <= 32'h0;
      end
    end else if (redirect_valid) begin
      count_reg      <= 2'd0;
      pending_reg    <= aligned;
      pending_pc_reg <= redirect_target;
      if (aligned)
        fetch_pc_reg <= redirect_target + 32'd4;
    end else begin
      pending_reg <= issue;
      if (issue) begin
        pending_pc_reg <= fetch_pc_reg;
        fetch_pc_reg   <= fetch_pc_reg + 32'd4;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        pc_q[0]   <= pc_q[1];
        inst_q[0] <= inst_q[1];
      end
      if (push) begin
        pc_q[wr_idx]   <= pending_pc_reg;
        inst_q[wr_idx] <= imem_inst;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end: owns the program counter, drives the address into the synchronous instruction memory (one-cycle registered read, big-endian word already assembled), and captures the returned word with its PC in a 2-entry buffer. Delivers a valid/ready stream of {pc, inst} to decode. Supports redirects (branch/jump/trap) from execute. Sustains one instruction per cycle when decode does not stall.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset release; must be word-aligned.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_addr  out  32  address to instruction memory; memory samples it at the next posedge and returns the word one cycle later.
- imem_inst  in  32  instruction word corresponding to the imem_addr of the previous cycle.
- redirect_valid  in  1  single-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  {out_pc, out_inst} valid to decode.
- out_ready  in  1  decode accepts this cycle.
- out_pc  out  32  PC of the delivered instruction.
- out_inst  out  32  delivered instruction word.
- fetch_error  out  1  misaligned-redirect flag (only with FETCH_MISALIGN_TRAP_EN).

## Operation
- State: fetch_pc (32b), pending (1b) + pending_pc (32b) for the read in flight, FIFO of 2 {pc, inst} entries with count 0..2, mode RUN/HALT (HALT exists only with the macro).
- pop = out_valid && out_ready; out_valid = (count != 0) && !redirect_valid; out_pc/out_inst = FIFO head.
- issue (normal) = mode==RUN && !redirect_valid && (count + pending - pop) < 2. On issue: imem_addr = fetch_pc; next pending=1, pending_pc=fetch_pc, fetch_pc += 4 (mod 2^32). No issue: pending<=0, fetch_pc holds, imem_addr = fetch_pc (data ignored).
- Capture: when pending==1, imem_inst is pushed with pending_pc at the edge ending that cycle (unless a redirect occurs that cycle). Push and pop in the same cycle are allowed; count never exceeds 2 by construction.
- Redirect (highest priority): FIFO cleared, in-flight word discarded, imem_addr = redirect_pc in the same cycle, pending<=1, pending_pc<=redirect_pc, fetch_pc<=redirect_pc+4, mode<=RUN. No handoff to decode occurs in a redirect cycle.
- Address wrap: fetch_pc wraps 32'hFFFF_FFFC -> 0; memory-side wrap on low 12 bits is the memory's concern.

## Timing
- Reset values: fetch_pc=RESET_PC, pending=0, count=0, mode=RUN, out_valid=0, out_pc=0, out_inst=0, fetch_error=0, imem_addr=RESET_PC.
- First cycle after reset release issues RESET_PC; out_valid=1 with out_pc=RESET_PC two cycles later.
- Redirect in cycle N: out_valid=0 in N and N+1; out_pc=redirect_pc valid in N+2.
- Steady state with out_ready=1: one instruction per cycle, consecutive PCs.
- out_ready low: at most two words buffered plus zero in flight; fetch stops, nothing lost. Resume: out_ready high delivers held entries next cycles with no bubble.
- Reset asserted mid-operation: all in-flight and buffered words dropped immediately; out_valid low asynchronously.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 flushes as normal, issues nothing, enters HALT, sets fetch_error=1 (sticky). In HALT no issue, out_valid=0. Cleared only by an aligned redirect (mode RUN, fetch_error=0 next edge) or reset.
- Not defined: redirect_pc[1:0] forced to 2'b00 before use; no HALT state; fetch_error port absent.

## Test plan
- Reset release, out_ready=1, memory holds 0x00000013 at 0,4,8 -> out_pc 0,4,8 on cycles 2,3,4, out_valid continuous.
- Hold out_ready=0 from cycle 2 for 5 cycles -> out_pc stays 0, count 2, no new issue; release -> 0,4,8 back-to-back, no duplicates/gaps.
- Redirect to 0x100 while two entries buffered -> out_valid=0 for 2 cycles, then out_pc=0x100, 0x104; stale entries never appear.
- Redirect on the same cycle as a pop and a capture -> pop suppressed, capture dropped, next delivery is redirect target.
- With macro: redirect to 0x102 -> fetch_error=1, out_valid=0 indefinitely; redirect to 0x200 -> fetch_error=0, out_pc=0x200 two cycles later. Without macro: redirect to 0x102 -> out_pc=0x100.
- Assert reset while pending=1, count=2 -> out_valid=0 immediately; after release fetch restarts at RESET_PC.
